prog_ram: RTL and testbench

- Parametrised CPU data/program RAM for the 8-bit bus machine, with a built-in bulk loader.
- The CPU port keeps the existing bus semantics: RI writes; DOUT reads combinationally and drives 0 while RI is high.
- The load port is a valid/ready stream. Once started, it fills every address in order from 0, so a program can be loaded with the CPU halted.
- Sits between the address register/bus and the external program source.

---
 rtl/prog_ram.sv | 121 ++++++++++++
 tb/tb_prog_ram.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_ram.sv
// CPU program/data RAM with a valid/ready bulk loader that fills every address from 0.
// Optional PROG_RAM_CLEAR_EN: reset sweeps zeros through the whole array before the CPU port opens.
module prog_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  CLK,
    input  logic                  RESETn,
    input  logic [ADDR_WIDTH-1:0] ADDR,
    input  logic [DATA_WIDTH-1:0] DIN,
    output logic [DATA_WIDTH-1:0] DOUT,
    input  logic                  RI,
    input  logic                  LD_START,
    input  logic [DATA_WIDTH-1:0] LD_DATA,
    input  logic                  LD_VALID,
    output logic                  LD_READY,
    output logic                  BUSY,
    output logic                  DONE
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FIN
`ifdef PROG_RAM_CLEAR_EN
        , CLEAR
`endif
    } state_t;

`ifdef PROG_RAM_CLEAR_EN
    localparam state_t RESET_STATE = CLEAR;
`else
    localparam state_t RESET_STATE = IDLE;
`endif

    state_t                  state;
    state_t                  next_state;
    logic [ADDR_WIDTH-1:0]   counter;
    logic                    last_addr;
    logic                    wr_en;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    assign last_addr = &counter;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state   <= RESET_STATE;
            counter <= '0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: if (LD_START) counter <= '0;
                LOAD: if (LD_VALID) counter <= counter + ADDR_WIDTH'(1);
`ifdef PROG_RAM_CLEAR_EN
                CLEAR: counter <= counter + ADDR_WIDTH'(1);
`endif
                default: counter <= counter;
            endcase
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (LD_START) next_state = LOAD;
            LOAD: if (LD_VALID && last_addr) next_state = FIN;
            FIN:  next_state = IDLE;
`ifdef PROG_RAM_CLEAR_EN
            CLEAR: if (last_addr) next_state = IDLE;
`endif
            default: next_state = IDLE;
        endcase
    end

    // A load request in IDLE takes priority over a same-cycle CPU write.
    always_comb begin
        LD_READY = 1'b0;
        BUSY     = 1'b0;
        DONE     = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = ADDR;
        wr_data  = DIN;
        case (state)
            IDLE: begin
                wr_en = RI && !LD_START;
            end
            LOAD: begin
                LD_READY = 1'b1;
                BUSY     = 1'b1;
                wr_en    = LD_VALID;
                wr_addr  = counter;
                wr_data  = LD_DATA;
            end
            FIN: begin
                DONE = 1'b1;
            end
`ifdef PROG_RAM_CLEAR_EN
            CLEAR: begin
                BUSY    = 1'b1;
                wr_en   = 1'b1;
                wr_addr = counter;
                wr_data = '0;
            end
`endif
            default: begin
                wr_en = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    assign DOUT = (state == IDLE && !RI) ? mem[ADDR] : '0;

endmodule

// File: tb/tb_prog_ram.sv
// Directed bench for prog_ram: CPU port, gapped bulk load, conflicts, reset abort, wide instance.
// Build with PROG_RAM_CLEAR_EN defined to exercise the clear-on-reset variant.
module tb_prog_ram;

    logic       CLK;
    logic       RESETn;
    logic [3:0] ADDR;
    logic [7:0] DIN;
    logic [7:0] DOUT;
    logic       RI;
    logic       LD_START;
    logic [7:0] LD_DATA;
    logic       LD_VALID;
    logic       LD_READY;
    logic       BUSY;
    logic       DONE;

    logic [5:0]  p_addr;
    logic [15:0] p_din;
    logic [15:0] p_dout;
    logic        p_ri;
    logic        p_ld_start;
    logic [15:0] p_ld_data;
    logic        p_ld_valid;
    logic        p_ld_ready;
    logic        p_busy;
    logic        p_done;

    int n_checks = 0;
    int n_fail   = 0;

    prog_ram dut (
        .CLK(CLK), .RESETn(RESETn), .ADDR(ADDR), .DIN(DIN), .DOUT(DOUT), .RI(RI),
        .LD_START(LD_START), .LD_DATA(LD_DATA), .LD_VALID(LD_VALID),
        .LD_READY(LD_READY), .BUSY(BUSY), .DONE(DONE)
    );

    prog_ram #(.DATA_WIDTH(16), .ADDR_WIDTH(6)) dut_wide (
        .CLK(CLK), .RESETn(RESETn), .ADDR(p_addr), .DIN(p_din), .DOUT(p_dout), .RI(p_ri),
        .LD_START(p_ld_start), .LD_DATA(p_ld_data), .LD_VALID(p_ld_valid),
        .LD_READY(p_ld_ready), .BUSY(p_busy), .DONE(p_done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic test_reset();
        RESETn = 1'b0;
        #3;
        n_checks++;
        if (LD_READY !== 1'b0 || DONE !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_ctrl: ready=%b done=%b, required 0/0", LD_READY, DONE);
        end
`ifdef PROG_RAM_CLEAR_EN
        n_checks++;
        if (BUSY !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL reset_busy: busy=%b, required 1", BUSY);
        end
        @(negedge CLK);
        RESETn = 1'b1;
        for (int c = 0; c < 16; c++) begin
            n_checks++;
            if (BUSY !== 1'b1 || LD_READY !== 1'b0 || DOUT !== 8'h00) begin
                n_fail++;
                $display("[TB] FAIL clear_cycle%0d: busy=%b ready=%b dout=%h, required 1/0/00",
                         c, BUSY, LD_READY, DOUT);
            end
            LD_START = (c >= 3 && c <= 5);
            @(negedge CLK);
        end
        LD_START = 1'b0;
        n_checks++;
        if (BUSY !== 1'b0 || LD_READY !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL clear_end: busy=%b ready=%b, required 0/0", BUSY, LD_READY);
        end
        for (int i = 0; i < 16; i++) begin
            ADDR = 4'(i);
            #1;
            n_checks++;
            if (DOUT !== 8'h00) begin
                n_fail++;
                $display("[TB] FAIL clear_read%0d: got %h required 00", i, DOUT);
            end
        end
`else
        n_checks++;
        if (BUSY !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_busy: busy=%b, required 0", BUSY);
        end
        @(negedge CLK);
        RESETn = 1'b1;
        @(negedge CLK);
`endif
    endtask

    task automatic test_cpu_rw();
        @(negedge CLK);
        ADDR = 4'd5; DIN = 8'hA7; RI = 1'b1;
        #1;
        n_checks++;
        if (DOUT !== 8'h00) begin
            n_fail++;
            $display("[TB] FAIL cpu_dout_during_ri: got %h required 00", DOUT);
        end
        @(negedge CLK);
        ADDR = 4'd15; DIN = 8'h3C;
        @(negedge CLK);
        RI = 1'b0; ADDR = 4'd5;
        #1;
        n_checks++;
        if (DOUT !== 8'hA7) begin
            n_fail++;
            $display("[TB] FAIL cpu_read5: got %h required a7", DOUT);
        end
        ADDR = 4'd15;
        #1;
        n_checks++;
        if (DOUT !== 8'h3C) begin
            n_fail++;
            $display("[TB] FAIL cpu_read15: got %h required 3c", DOUT);
        end
    endtask

    task automatic test_full_load();
        int done_pulses = 0;
        @(negedge CLK);
        LD_START = 1'b1;
        @(negedge CLK);
        LD_START = 1'b0;
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (LD_READY !== 1'b1 || BUSY !== 1'b1 || DONE !== 1'b0 || DOUT !== 8'h00) begin
                n_fail++;
                $display("[TB] FAIL load_word%0d: ready=%b busy=%b done=%b dout=%h, required 1/1/0/00",
                         i, LD_READY, BUSY, DONE, DOUT);
            end
            LD_VALID = 1'b1;
            LD_DATA  = 8'h10 + 8'(i);
            @(negedge CLK);
            LD_VALID = 1'b0;
            if (DONE === 1'b1) done_pulses++;
            if (i % 3 == 2 && i < 15) begin
                repeat (2) begin
                    n_checks++;
                    if (LD_READY !== 1'b1 || BUSY !== 1'b1 || DONE !== 1'b0) begin
                        n_fail++;
                        $display("[TB] FAIL load_gap%0d: ready=%b busy=%b done=%b, required 1/1/0",
                                 i, LD_READY, BUSY, DONE);
                    end
                    @(negedge CLK);
                end
            end
        end
        n_checks++;
        if (DONE !== 1'b1 || BUSY !== 1'b0 || LD_READY !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL load_fin: done=%b busy=%b ready=%b, required 1/0/0", DONE, BUSY, LD_READY);
        end
        @(negedge CLK);
        if (DONE === 1'b1) done_pulses++;
        n_checks++;
        if (done_pulses != 1) begin
            n_fail++;
            $display("[TB] FAIL load_done_count: got %0d required 1", done_pulses);
        end
        for (int i = 0; i < 16; i++) begin
            ADDR = 4'(i);
            #1;
            n_checks++;
            if (DOUT !== 8'h10 + 8'(i)) begin
                n_fail++;
                $display("[TB] FAIL load_read%0d: got %h required %h", i, DOUT, 8'h10 + 8'(i));
            end
        end
    endtask

    task automatic test_conflicts();
        @(negedge CLK);
        ADDR = 4'd3; DIN = 8'hFF; RI = 1'b1; LD_START = 1'b1;
        @(negedge CLK);
        LD_START = 1'b0;
        n_checks++;
        if (LD_READY !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL conflict_start: ready=%b required 1", LD_READY);
        end
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (DOUT !== 8'h00 || DONE !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL conflict_word%0d: dout=%h done=%b, required 00/0", i, DOUT, DONE);
            end
            LD_START = (i == 7);
            LD_VALID = 1'b1;
            LD_DATA  = 8'h20 + 8'(i);
            @(negedge CLK);
        end
        LD_VALID = 1'b0; LD_START = 1'b0;
        n_checks++;
        if (DONE !== 1'b1 || DOUT !== 8'h00) begin
            n_fail++;
            $display("[TB] FAIL conflict_fin: done=%b dout=%h, required 1/00", DONE, DOUT);
        end
        RI = 1'b0;
        @(negedge CLK);
        for (int i = 0; i < 16; i++) begin
            ADDR = 4'(i);
            #1;
            n_checks++;
            if (DOUT !== 8'h20 + 8'(i)) begin
                n_fail++;
                $display("[TB] FAIL conflict_read%0d: got %h required %h", i, DOUT, 8'h20 + 8'(i));
            end
        end
    endtask

    task automatic test_reset_mid_load();
        @(negedge CLK);
        LD_START = 1'b1;
        @(negedge CLK);
        LD_START = 1'b0;
        for (int i = 0; i < 6; i++) begin
            LD_VALID = 1'b1;
            LD_DATA  = 8'h40 + 8'(i);
            @(negedge CLK);
        end
        LD_DATA = 8'h46;
        #2;
        RESETn = 1'b0;
        #1;
        n_checks++;
`ifdef PROG_RAM_CLEAR_EN
        if (LD_READY !== 1'b0 || BUSY !== 1'b1 || DONE !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL abort_outputs: ready=%b busy=%b done=%b, required 0/1/0", LD_READY, BUSY, DONE);
        end
`else
        if (LD_READY !== 1'b0 || BUSY !== 1'b0 || DONE !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL abort_outputs: ready=%b busy=%b done=%b, required 0/0/0", LD_READY, BUSY, DONE);
        end
`endif
        @(negedge CLK);
        LD_VALID = 1'b0;
        n_checks++;
        if (DONE !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL abort_no_done: done=%b required 0", DONE);
        end
        RESETn = 1'b1;
`ifdef PROG_RAM_CLEAR_EN
        repeat (17) @(negedge CLK);
        for (int i = 0; i < 7; i++) begin
            ADDR = 4'(i);
            #1;
            n_checks++;
            if (DOUT !== 8'h00) begin
                n_fail++;
                $display("[TB] FAIL abort_clear_read%0d: got %h required 00", i, DOUT);
            end
        end
`else
        @(negedge CLK);
        for (int i = 0; i < 7; i++) begin
            logic [7:0] expected;
            expected = (i < 6) ? 8'h40 + 8'(i) : 8'h26;
            ADDR = 4'(i);
            #1;
            n_checks++;
            if (DOUT !== expected) begin
                n_fail++;
                $display("[TB] FAIL abort_read%0d: got %h required %h", i, DOUT, expected);
            end
        end
`endif
    endtask

    task automatic test_param_sweep();
        int waited = 0;
        while (p_busy !== 1'b0 && waited < 200) begin
            @(negedge CLK);
            waited++;
        end
        n_checks++;
        if (p_busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL wide_idle_timeout: busy=%b required 0", p_busy);
        end
        @(negedge CLK);
        p_ld_start = 1'b1;
        @(negedge CLK);
        p_ld_start = 1'b0;
        for (int i = 0; i < 64; i++) begin
            n_checks++;
            if (p_ld_ready !== 1'b1 || p_done !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL wide_word%0d: ready=%b done=%b, required 1/0", i, p_ld_ready, p_done);
            end
            p_ld_valid = 1'b1;
            p_ld_data  = 16'hA500 + 16'(i);
            @(negedge CLK);
        end
        p_ld_valid = 1'b0;
        n_checks++;
        if (p_done !== 1'b1 || p_busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL wide_fin: done=%b busy=%b, required 1/0", p_done, p_busy);
        end
        @(negedge CLK);
        for (int i = 0; i < 64; i++) begin
            p_addr = 6'(i);
            #1;
            n_checks++;
            if (p_dout !== 16'hA500 + 16'(i)) begin
                n_fail++;
                $display("[TB] FAIL wide_read%0d: got %h required %h", i, p_dout, 16'hA500 + 16'(i));
            end
        end
    endtask

    initial begin
        ADDR = '0; DIN = '0; RI = 1'b0; LD_START = 1'b0; LD_DATA = '0; LD_VALID = 1'b0;
        p_addr = '0; p_din = '0; p_ri = 1'b0; p_ld_start = 1'b0; p_ld_data = '0; p_ld_valid = 1'b0;
        test_reset();
        test_cpu_rw();
        test_full_load();
        test_conflicts();
        test_reset_mid_load();
        test_param_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
